// File: rtl/alu_seq_param.sv
// alu_seq_param: parametrised sequential ALU, one op per valid/ready handshake, registered result + NZCV.
// Latency: consumer samples out_valid at the 2nd edge after the accept edge (MUL: WIDTH+2 edges).
// Backpressure: result/flags held in DONE until out_ready&en; in_ready only in IDLE. Multiplier built when ALU_MUL_EN is defined.
module alu_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             illegal
);

    // Shift-amount width is always derived from WIDTH, never set independently.
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LSL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ASR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL_BUSY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

    state_t state;
    state_t state_nx;

    // Control strobes decoded from the current state (all already qualified by en)
    logic capture;
    logic load_exec;

    // Captured operation; later changes on the input ports are ignored
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Single-cycle datapath intermediates
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH:0]   lsl_full;
    logic [WIDTH:0]   lsr_full;
    logic [WIDTH:0]   asr_full;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] alu_nz;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;
    logic [3:0]       alu_flags;

`ifdef ALU_MUL_EN
    // Iteration counter must reach WIDTH itself, hence one bit wider than SHW
    localparam logic [SHW:0] MUL_ITERS = (SHW+1)'(WIDTH);

    logic             mul_step;
    logic             load_mul;
    logic             mul_last;
    logic [SHW:0]     mul_cnt;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH:0]   mul_sum;
`endif

    // State register: frozen while en is low, async return to IDLE on rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (en) begin
            state <= state_nx;
        end
    end

    // Next-state logic: IDLE -> EXEC/MUL_BUSY -> DONE -> IDLE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (capture) begin
`ifdef ALU_MUL_EN
                    state_nx = (opcode == OP_MUL) ? S_MUL_BUSY : S_EXEC;
`else
                    state_nx = S_EXEC;
`endif
                end
            end
            S_EXEC: state_nx = S_DONE;
`ifdef ALU_MUL_EN
            S_MUL_BUSY: begin
                if (mul_last) begin
                    state_nx = S_DONE;
                end
            end
`endif
            // No bypass: a new op can only be accepted once back in IDLE
            S_DONE: begin
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output/strobe decode: handshake signals and datapath load enables
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        load_exec = 1'b0;
`ifdef ALU_MUL_EN
        mul_step  = 1'b0;
        load_mul  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                in_ready = en & ~rst;
                capture  = in_valid & en & ~rst;
            end
            S_EXEC: load_exec = en;
`ifdef ALU_MUL_EN
            S_MUL_BUSY: begin
                mul_step = en & ~mul_last;
                load_mul = en & mul_last;
            end
`endif
            S_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture on the accept edge; b_q doubles as the multiplier shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (capture) begin
            op_q <= opcode;
            a_q  <= operand1;
            b_q  <= operand2;
        end
`ifdef ALU_MUL_EN
        else if (mul_step) begin
            b_q <= {mul_sum[0], b_q[WIDTH-1:1]};
        end
`endif
    end

    // Extended-width arithmetic so carries and shifted-out bits fall out of the top/bottom bit
    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign sub_full = {1'b0, a_q} - {1'b0, b_q};
    assign shamt    = b_q[SHW-1:0];
    assign lsl_full = {1'b0, a_q} << shamt;
    assign lsr_full = {a_q, 1'b0} >> shamt;
    assign asr_full = $unsigned($signed({a_q, 1'b0}) >>> shamt);

    // Single-cycle op decode: result, the value N/Z are derived from, C and V
    always_comb begin
        alu_res = '0;
        alu_nz  = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                // CMP keeps the SUB flags but never exposes the difference
                alu_res = (op_q == OP_CMP) ? '0 : sub_full[WIDTH-1:0];
                alu_nz  = sub_full[WIDTH-1:0];
                alu_c   = ~sub_full[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_full[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_LSL: begin
                alu_res = lsl_full[WIDTH-1:0];
                alu_c   = lsl_full[WIDTH];
            end
            OP_LSR: begin
                alu_res = lsr_full[WIDTH:1];
                alu_c   = lsr_full[0];
            end
            OP_ASR: begin
                alu_res = asr_full[WIDTH:1];
                alu_c   = asr_full[0];
            end
`ifndef ALU_MUL_EN
            // Without the multiplier, MUL is just another unsupported opcode
            OP_MUL: alu_ill = 1'b1;
`endif
            default: alu_ill = 1'b1;
        endcase
        if (op_q != OP_SUB && op_q != OP_CMP) begin
            alu_nz = alu_res;
        end
        alu_flags = alu_ill ? 4'b0000 : {alu_nz[WIDTH-1], (alu_nz == '0), alu_c, alu_v};
    end

`ifdef ALU_MUL_EN
    // One partial product per cycle: conditionally add A into the high half, then shift right
    assign mul_sum  = {1'b0, mul_hi} + (b_q[0] ? {1'b0, a_q} : '0);
    assign mul_last = (mul_cnt == MUL_ITERS);

    // Multiplier high half and iteration counter, cleared on every accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_hi  <= '0;
            mul_cnt <= '0;
        end else if (capture) begin
            mul_hi  <= '0;
            mul_cnt <= '0;
        end else if (mul_step) begin
            mul_hi  <= mul_sum[WIDTH:1];
            mul_cnt <= mul_cnt + 1'b1;
        end
    end
`endif

    // Result/flag registers: loaded on completion, held through DONE until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
            illegal   <= 1'b0;
        end else if (load_exec) begin
            result    <= alu_res;
            result_hi <= '0;
            flags     <= alu_flags;
            illegal   <= alu_ill;
        end
`ifdef ALU_MUL_EN
        else if (load_mul) begin
            // Z covers the full double-width product, V flags a non-zero high half
            result    <= b_q;
            result_hi <= mul_hi;
            flags     <= {b_q[WIDTH-1], ({mul_hi, b_q} == '0), 1'b0, (mul_hi != '0)};
            illegal   <= 1'b0;
        end
`endif
    end

endmodule
